// File: rtl/dma_arbiter_pkg.sv
// Shared definitions for the DMA channel arbiter: FSM state encodings,
// default data width and the pointer-width helper.
package dma_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        RELEASE = 2'd2
    } arb_state_e;

    localparam int AW_DEFAULT = 16;

    // A single-device arbiter still needs a 1-bit pointer to keep port widths legal.
    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dma_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request searching upward from
// pointer+1 (mod N_DEV). Optional macro DMA_ARB_PRIO0_EN gives device 0 absolute priority.
module dma_arbiter_rr_picker
    import dma_arbiter_pkg::*;
#(
    parameter int N_DEV = 4,
    parameter int PW    = ptr_width(N_DEV)
) (
    input  logic [N_DEV-1:0] i_req,
    input  logic [PW-1:0]    i_ptr,
    output logic [N_DEV-1:0] o_pick,
    output logic [PW-1:0]    o_idx,
    output logic             o_valid,
    output logic             o_upd_ptr
);

    always_comb begin : p_pick
        int w_slot;
        w_slot    = 0;
        o_pick    = '0;
        o_idx     = '0;
        o_valid   = 1'b0;
        o_upd_ptr = 1'b0;
        for (int k = 1; k <= N_DEV; k++) begin
            w_slot = (int'(i_ptr) + k) % N_DEV;
            if (!o_valid && i_req[PW'(w_slot)]) begin
                o_pick[PW'(w_slot)] = 1'b1;
                o_idx               = PW'(w_slot);
                o_valid             = 1'b1;
                o_upd_ptr           = 1'b1;
            end
        end
`ifdef DMA_ARB_PRIO0_EN
        // Device 0 wins outright and leaves the rotation untouched for the others.
        if (i_req[0]) begin
            o_pick    = '0;
            o_pick[0] = 1'b1;
            o_idx     = '0;
            o_valid   = 1'b1;
            o_upd_ptr = 1'b0;
        end
`endif
    end

endmodule

// File: rtl/dma_arbiter.sv
// Shares one DMA controller channel among N_DEV peripherals, granting whole transfers
// round-robin; build with DMA_ARB_PRIO0_EN to give device 0 absolute priority in IDLE.
module dma_arbiter
    import dma_arbiter_pkg::*;
#(
    parameter int N_DEV = 4,
    parameter int AW    = AW_DEFAULT
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [N_DEV-1:0]    req_rqst,
    input  logic [N_DEV-1:0]    req_rd_wr,
    input  logic [N_DEV*AW-1:0] req_start_address,
    input  logic [N_DEV*AW-1:0] req_num_words,
    input  logic [N_DEV*AW-1:0] req_dev_out,
    input  logic [N_DEV-1:0]    req_dev_ack,
    output logic [N_DEV-1:0]    req_dma_ack,
    output logic [N_DEV-1:0]    req_dma_end_flag,
    output logic                ctl_rqst,
    output logic                ctl_rd_wr,
    output logic [AW-1:0]       ctl_start_address,
    output logic [AW-1:0]       ctl_num_words,
    output logic [AW-1:0]       ctl_dev_out,
    output logic                ctl_dev_ack,
    input  logic                dma_ack,
    input  logic                dma_end_flag,
    output logic [N_DEV-1:0]    grant,
    output logic                busy,
    output logic [1:0]          o_dbg_state
);

    localparam int PW = ptr_width(N_DEV);

    // Handshake: ctl_rqst is held high from the cycle after a grant until the cycle
    // after dma_end_flag (or an abort); dma_ack/dma_end_flag are single-cycle strobes
    // from the controller, forwarded combinationally to the granted device only.

    arb_state_e       r_state, w_state_nx;
    logic [N_DEV-1:0] r_grant, w_grant_nx;
    logic [PW-1:0]    r_ptr,   w_ptr_nx;
    logic             r_ctl_rqst;
    logic             r_busy;

    logic [N_DEV-1:0] w_pick;
    logic [PW-1:0]    w_pick_idx;
    logic             w_pick_valid;
    logic             w_upd_ptr;

    dma_arbiter_rr_picker #(
        .N_DEV (N_DEV),
        .PW    (PW)
    ) u_picker (
        .i_req     (req_rqst),
        .i_ptr     (r_ptr),
        .o_pick    (w_pick),
        .o_idx     (w_pick_idx),
        .o_valid   (w_pick_valid),
        .o_upd_ptr (w_upd_ptr)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_grant    <= '0;
            r_ptr      <= PW'(N_DEV - 1);
            r_ctl_rqst <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_grant    <= w_grant_nx;
            r_ptr      <= w_ptr_nx;
            r_ctl_rqst <= |w_grant_nx;
            r_busy     <= |w_grant_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_grant_nx = r_grant;
        w_ptr_nx   = r_ptr;
        case (r_state)
            IDLE: begin
                if (w_pick_valid) begin
                    w_grant_nx = w_pick;
                    w_state_nx = BUSY;
                    if (w_upd_ptr) w_ptr_nx = w_pick_idx;
                end
            end
            BUSY: begin
                // End wins over a simultaneous request drop so the device still sees RELEASE.
                if (dma_end_flag) begin
                    w_grant_nx = '0;
                    w_state_nx = RELEASE;
                end else if ((req_rqst & r_grant) == '0) begin
                    w_grant_nx = '0;
                    w_state_nx = IDLE;
                end
            end
            RELEASE: begin
                w_grant_nx = '0;
                w_state_nx = IDLE;
            end
            default: begin
                w_grant_nx = '0;
                w_state_nx = IDLE;
            end
        endcase
    end

    // AND-OR mux keyed on the registered grant; everything reads zero when nothing is granted.
    always_comb begin
        ctl_rd_wr         = 1'b0;
        ctl_start_address = '0;
        ctl_num_words     = '0;
        ctl_dev_out       = '0;
        for (int i = 0; i < N_DEV; i++) begin
            if (r_grant[i]) begin
                ctl_rd_wr         = ctl_rd_wr | req_rd_wr[i];
                ctl_start_address = ctl_start_address | req_start_address[i*AW +: AW];
                ctl_num_words     = ctl_num_words | req_num_words[i*AW +: AW];
                ctl_dev_out       = ctl_dev_out | req_dev_out[i*AW +: AW];
            end
        end
    end

    assign ctl_dev_ack      = |(req_dev_ack & r_grant);
    assign req_dma_ack      = r_grant & {N_DEV{dma_ack}};
    assign req_dma_end_flag = r_grant & {N_DEV{dma_end_flag}};

    assign ctl_rqst    = r_ctl_rqst;
    assign busy        = r_busy;
    assign grant       = r_grant;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_dma_arbiter.sv
// Directed self-checking bench for dma_arbiter (N_DEV=4, AW=16); expectations for
// the device-0 priority case follow DMA_ARB_PRIO0_EN when it is defined.
module tb_dma_arbiter;

    localparam int N  = 4;
    localparam int AW = 16;

    logic            clk;
    logic            reset;
    logic [N-1:0]    req_rqst;
    logic [N-1:0]    req_rd_wr;
    logic [N*AW-1:0] req_start_address;
    logic [N*AW-1:0] req_num_words;
    logic [N*AW-1:0] req_dev_out;
    logic [N-1:0]    req_dev_ack;
    logic [N-1:0]    req_dma_ack;
    logic [N-1:0]    req_dma_end_flag;
    logic            ctl_rqst;
    logic            ctl_rd_wr;
    logic [AW-1:0]   ctl_start_address;
    logic [AW-1:0]   ctl_num_words;
    logic [AW-1:0]   ctl_dev_out;
    logic            ctl_dev_ack;
    logic            dma_ack;
    logic            dma_end_flag;
    logic [N-1:0]    grant;
    logic            busy;
    logic [1:0]      o_dbg_state;

    int tests_run;
    int tests_failed;

    dma_arbiter #(.N_DEV(N), .AW(AW)) dut (
        .clk               (clk),
        .reset             (reset),
        .req_rqst          (req_rqst),
        .req_rd_wr         (req_rd_wr),
        .req_start_address (req_start_address),
        .req_num_words     (req_num_words),
        .req_dev_out       (req_dev_out),
        .req_dev_ack       (req_dev_ack),
        .req_dma_ack       (req_dma_ack),
        .req_dma_end_flag  (req_dma_end_flag),
        .ctl_rqst          (ctl_rqst),
        .ctl_rd_wr         (ctl_rd_wr),
        .ctl_start_address (ctl_start_address),
        .ctl_num_words     (ctl_num_words),
        .ctl_dev_out       (ctl_dev_out),
        .ctl_dev_ack       (ctl_dev_ack),
        .dma_ack           (dma_ack),
        .dma_end_flag      (dma_end_flag),
        .grant             (grant),
        .busy              (busy),
        .o_dbg_state       (o_dbg_state)
    );

    // ---- clock / reset ----
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic apply_reset();
        reset             = 1'b1;
        req_rqst          = '0;
        req_rd_wr         = '0;
        req_start_address = '0;
        req_num_words     = '0;
        req_dev_out       = '0;
        req_dev_ack       = '0;
        dma_ack           = 1'b0;
        dma_end_flag      = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    // ---- scenarios ----
    task automatic test_reset();
        reset = 1'b1;
        #1;
        tests_run++;
        if (grant !== 4'b0000 || ctl_rqst !== 1'b0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_regs: grant=%b ctl_rqst=%b busy=%b required 0000/0/0", grant, ctl_rqst, busy);
        end
        tests_run++;
        if (o_dbg_state !== 2'd0 || ctl_start_address !== 16'h0 || req_dma_ack !== 4'b0) begin
            tests_failed++;
            $display("FAIL reset_outs: state=%0d addr=%h dma_ack=%b required 0/0000/0000", o_dbg_state, ctl_start_address, req_dma_ack);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_single();
        apply_reset();
        req_start_address[2*AW +: AW] = 16'h0200;
        req_num_words[2*AW +: AW]     = 16'd3;
        req_dev_out[2*AW +: AW]       = 16'hA5A5;
        req_start_address[1*AW +: AW] = 16'h1111;
        req_rd_wr[2]                  = 1'b1;
        req_rqst                      = 4'b0100;
        tick();
        tests_run++;
        if (grant !== 4'b0100 || ctl_rqst !== 1'b1 || busy !== 1'b1 || o_dbg_state !== 2'd1) begin
            tests_failed++;
            $display("FAIL single_grant: grant=%b ctl_rqst=%b busy=%b state=%0d required 0100/1/1/1", grant, ctl_rqst, busy, o_dbg_state);
        end
        tests_run++;
        if (ctl_start_address !== 16'h0200 || ctl_num_words !== 16'd3 || ctl_rd_wr !== 1'b1 || ctl_dev_out !== 16'hA5A5) begin
            tests_failed++;
            $display("FAIL single_mux: addr=%h words=%0d rd_wr=%b data=%h required 0200/3/1/a5a5", ctl_start_address, ctl_num_words, ctl_rd_wr, ctl_dev_out);
        end
        req_dev_ack[2] = 1'b1;
        #1;
        tests_run++;
        if (ctl_dev_ack !== 1'b1) begin
            tests_failed++;
            $display("FAIL single_dev_ack: ctl_dev_ack=%b required 1", ctl_dev_ack);
        end
        req_dev_ack = 4'b1011;
        #1;
        tests_run++;
        if (ctl_dev_ack !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_dev_ack_other: ctl_dev_ack=%b required 0", ctl_dev_ack);
        end
        req_dev_ack = '0;
        for (int k = 0; k < 3; k++) begin
            dma_ack = 1'b1;
            #1;
            tests_run++;
            if (req_dma_ack !== 4'b0100) begin
                tests_failed++;
                $display("FAIL single_ack%0d: req_dma_ack=%b required 0100", k, req_dma_ack);
            end
            tick();
            dma_ack = 1'b0;
            #1;
            tests_run++;
            if (req_dma_ack !== 4'b0000) begin
                tests_failed++;
                $display("FAIL single_ack_low%0d: req_dma_ack=%b required 0000", k, req_dma_ack);
            end
            tick();
        end
        dma_end_flag = 1'b1;
        #1;
        tests_run++;
        if (req_dma_end_flag !== 4'b0100) begin
            tests_failed++;
            $display("FAIL single_end_fwd: req_dma_end_flag=%b required 0100", req_dma_end_flag);
        end
        tick();
        dma_end_flag = 1'b0;
        req_rqst     = '0;
        #1;
        tests_run++;
        if (grant !== 4'b0 || ctl_rqst !== 1'b0 || busy !== 1'b0 || o_dbg_state !== 2'd2 || ctl_start_address !== 16'h0) begin
            tests_failed++;
            $display("FAIL single_release: grant=%b ctl_rqst=%b busy=%b state=%0d addr=%h required 0000/0/0/2/0000", grant, ctl_rqst, busy, o_dbg_state, ctl_start_address);
        end
        tick();
        tests_run++;
        if (o_dbg_state !== 2'd0 || grant !== 4'b0) begin
            tests_failed++;
            $display("FAIL single_idle: state=%0d grant=%b required 0/0000", o_dbg_state, grant);
        end
    endtask

    task automatic test_contention();
        logic [N-1:0] exp_g [4];
        exp_g[0] = 4'b0001;
        exp_g[1] = 4'b0010;
        exp_g[2] = 4'b1000;
        exp_g[3] = 4'b0001;
        apply_reset();
        req_rqst = 4'b1011;
        for (int k = 0; k < 4; k++) begin
            tick();
            tests_run++;
            if (grant !== exp_g[k] || ctl_rqst !== 1'b1) begin
                tests_failed++;
                $display("FAIL contention_grant%0d: grant=%b ctl_rqst=%b required %b/1", k, grant, ctl_rqst, exp_g[k]);
            end
            dma_end_flag = 1'b1;
            tick();
            dma_end_flag = 1'b0;
            tests_run++;
            if (grant !== 4'b0 || o_dbg_state !== 2'd2) begin
                tests_failed++;
                $display("FAIL contention_gap1_%0d: grant=%b state=%0d required 0000/2", k, grant, o_dbg_state);
            end
            tick();
            tests_run++;
            if (grant !== 4'b0 || o_dbg_state !== 2'd0) begin
                tests_failed++;
                $display("FAIL contention_gap2_%0d: grant=%b state=%0d required 0000/0", k, grant, o_dbg_state);
            end
            if (k == 3) req_rqst = '0;
        end
        tick();
        tests_run++;
        if (grant !== 4'b0) begin
            tests_failed++;
            $display("FAIL contention_drain: grant=%b required 0000", grant);
        end
    endtask

    task automatic test_abort();
        apply_reset();
        req_rqst = 4'b0010;
        tick();
        tests_run++;
        if (grant !== 4'b0010) begin
            tests_failed++;
            $display("FAIL abort_grant: grant=%b required 0010", grant);
        end
        dma_ack = 1'b1;
        #1;
        tests_run++;
        if (req_dma_ack !== 4'b0010) begin
            tests_failed++;
            $display("FAIL abort_ack: req_dma_ack=%b required 0010", req_dma_ack);
        end
        tick();
        dma_ack  = 1'b0;
        req_rqst = 4'b0100;
        tick();
        tests_run++;
        if (grant !== 4'b0 || ctl_rqst !== 1'b0 || o_dbg_state !== 2'd0 || req_dma_end_flag !== 4'b0) begin
            tests_failed++;
            $display("FAIL abort_drop: grant=%b ctl_rqst=%b state=%0d end=%b required 0000/0/0/0000", grant, ctl_rqst, o_dbg_state, req_dma_end_flag);
        end
        tick();
        tests_run++;
        if (grant !== 4'b0100 || ctl_rqst !== 1'b1) begin
            tests_failed++;
            $display("FAIL abort_next: grant=%b ctl_rqst=%b required 0100/1", grant, ctl_rqst);
        end
        dma_end_flag = 1'b1;
        req_rqst     = '0;
        tick();
        dma_end_flag = 1'b0;
        tests_run++;
        if (o_dbg_state !== 2'd2) begin
            tests_failed++;
            $display("FAIL abort_end_wins: state=%0d required 2", o_dbg_state);
        end
        tick();
    endtask

    task automatic test_stray();
        apply_reset();
        dma_ack      = 1'b1;
        dma_end_flag = 1'b1;
        #1;
        tests_run++;
        if (req_dma_ack !== 4'b0 || req_dma_end_flag !== 4'b0) begin
            tests_failed++;
            $display("FAIL stray_fwd: req_dma_ack=%b req_dma_end_flag=%b required 0000/0000", req_dma_ack, req_dma_end_flag);
        end
        tick();
        tests_run++;
        if (o_dbg_state !== 2'd0 || grant !== 4'b0 || ctl_rqst !== 1'b0) begin
            tests_failed++;
            $display("FAIL stray_state: state=%0d grant=%b ctl_rqst=%b required 0/0000/0", o_dbg_state, grant, ctl_rqst);
        end
        dma_ack      = 1'b0;
        dma_end_flag = 1'b0;
    endtask

    task automatic test_reset_mid_busy();
        apply_reset();
        req_start_address[3*AW +: AW] = 16'h3300;
        req_rqst = 4'b1000;
        tick();
        tests_run++;
        if (grant !== 4'b1000 || ctl_start_address !== 16'h3300) begin
            tests_failed++;
            $display("FAIL rst_busy_grant: grant=%b addr=%h required 1000/3300", grant, ctl_start_address);
        end
        req_rqst = 4'b1111;
        #2;
        reset = 1'b1;
        #1;
        tests_run++;
        if (grant !== 4'b0 || ctl_rqst !== 1'b0 || busy !== 1'b0 || ctl_start_address !== 16'h0) begin
            tests_failed++;
            $display("FAIL rst_busy_drop: grant=%b ctl_rqst=%b busy=%b addr=%h required 0000/0/0/0000", grant, ctl_rqst, busy, ctl_start_address);
        end
        tick();
        reset = 1'b0;
        tick();
        tests_run++;
        if (grant !== 4'b0001) begin
            tests_failed++;
            $display("FAIL rst_busy_first: grant=%b required 0001", grant);
        end
        req_rqst     = '0;
        dma_end_flag = 1'b1;
        tick();
        dma_end_flag = 1'b0;
        tick();
    endtask

    task automatic test_prio0();
        logic [N-1:0] exp_first;
`ifdef DMA_ARB_PRIO0_EN
        exp_first = 4'b0001;
`else
        exp_first = 4'b0010;
`endif
        apply_reset();
        req_rqst = 4'b0001;
        tick();
        tests_run++;
        if (grant !== 4'b0001) begin
            tests_failed++;
            $display("FAIL prio_setup: grant=%b required 0001", grant);
        end
        dma_end_flag = 1'b1;
        tick();
        dma_end_flag = 1'b0;
        req_rqst     = 4'b0011;
        tick();
        tick();
        tests_run++;
        if (grant !== exp_first) begin
            tests_failed++;
            $display("FAIL prio_first: grant=%b required %b", grant, exp_first);
        end
        dma_end_flag = 1'b1;
        tick();
        dma_end_flag = 1'b0;
        tick();
        tick();
        tests_run++;
        if (grant !== 4'b0001) begin
            tests_failed++;
            $display("FAIL prio_second: grant=%b required 0001", grant);
        end
        req_rqst     = '0;
        dma_end_flag = 1'b1;
        tick();
        dma_end_flag = 1'b0;
        tick();
    endtask

    // ---- sequence and report ----
    initial begin
        tests_run    = 0;
        tests_failed = 0;
        apply_reset();
        test_reset();
        test_single();
        test_contention();
        test_abort();
        test_stray();
        test_reset_mid_busy();
        test_prio0();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/dma_arbiter.md
Name: dma_arbiter

Overview:
- Shares one DMA controller channel between N_DEV DMA-capable peripherals (simple_dma_device class).
- Sits between the peripherals' DMA-side ports and the controller.
- Arbitrates whole transfers round-robin and holds the grant until the controller raises dma_end_flag.
- Muxes the granted device's request fields to the controller and routes the controller's ack and end strobes back to the granted device only.

Parameters:
- N_DEV, 4, number of requesting devices (1..8).
- AW, 16, address/word-count/data width.

Ports:
- clk  in  1  main system clock
- reset  in  1  asynchronous active-high reset
- req_rqst  in  N_DEV  per-device DMA request (level)
- req_rd_wr  in  N_DEV  per-device direction, 1 = read, 0 = write
- req_start_address  in  N_DEV*AW  flattened start addresses, device i at [i*AW +: AW]
- req_num_words  in  N_DEV*AW  flattened word counts
- req_dev_out  in  N_DEV*AW  flattened write data
- req_dev_ack  in  N_DEV  per-device handshake ack
- req_dma_ack  out  N_DEV  controller ack routed to granted device
- req_dma_end_flag  out  N_DEV  end-of-transfer routed to granted device
- ctl_rqst  out  1  request to controller
- ctl_rd_wr  out  1  granted direction
- ctl_start_address  out  AW  granted start address
- ctl_num_words  out  AW  granted word count
- ctl_dev_out  out  AW  granted write data
- ctl_dev_ack  out  1  granted handshake ack
- dma_ack  in  1  controller ack
- dma_end_flag  in  1  controller end-of-transfer
- grant  out  N_DEV  one-hot registered grant
- busy  out  1  transfer in progress

Behaviour:
- FSM states: IDLE, BUSY, RELEASE. Reset: state=IDLE, grant=0, rr pointer=N_DEV-1.
- All ctl_* outputs and req_dma_* outputs are 0 at reset and whenever grant=0.
- ctl_rqst, busy and grant are registered.
- ctl_rd_wr, ctl_start_address, ctl_num_words, ctl_dev_out and ctl_dev_ack are combinational muxes of the granted slot.
- IDLE:
  - If req_rqst != 0, pick the first set bit searching from pointer+1 upward, wrapping modulo N_DEV.
  - Next cycle: grant = that one-hot, ctl_rqst=1, busy=1, pointer=index, state -> BUSY.
  - Request-to-ctl_rqst latency is exactly 1 cycle.
- BUSY:
  - req_dma_ack = grant & {N{dma_ack}}; req_dma_end_flag = grant & {N{dma_end_flag}}. Both are combinational, with zero added latency.
  - On dma_end_flag: ctl_rqst->0, grant->0, state -> RELEASE.
  - On the granted req_rqst bit falling without dma_end_flag (abort): ctl_rqst->0, grant->0, state -> IDLE.
  - If the abort and dma_end_flag coincide, the end takes precedence and the state goes to RELEASE.
  - Other devices' requests are ignored while BUSY. There is no preemption.
- RELEASE:
  - One dead cycle with all outputs deasserted, so the finished device's request has time to drop.
  - state -> IDLE unconditionally.
  - Back-to-back grant gap is therefore 2 cycles after dma_end_flag.
- dma_ack and dma_end_flag in the same cycle: both are forwarded.
- dma_ack or dma_end_flag while IDLE or RELEASE: ignored and not forwarded.
- grant is always one-hot or zero.
- N_DEV=1: the pointer is constant and behaviour reduces to a gated passthrough plus the RELEASE gap.
- Asynchronous reset mid-BUSY: outputs drop immediately. The controller must also be reset by the same reset.

Optional Feature:
- Macro: DMA_ARB_PRIO0_EN.
- Defined: device 0 has absolute priority in IDLE. If req_rqst[0]=1 it wins regardless of the pointer, and the pointer is not updated. Remaining devices stay round-robin.
- Undefined: pure round-robin for all devices.
- Neither setting preempts a BUSY transfer.

Decomposition:
- Shared package/header dma_arb_defs: state encodings (IDLE=2'd0, BUSY=2'd1, RELEASE=2'd2) and AW default.
- Sub-module dma_rr_picker: combinational; inputs req vector and pointer; outputs one-hot pick and its index; handles the PRIO0 override.
- The FSM and muxes stay in dma_arbiter.

Test Plan:
- Single request: req_rqst=4'b0100, start_address[2]=16'h0200, num_words[2]=16'd3.
  - Next cycle: grant=4'b0100, ctl_rqst=1, ctl_start_address=16'h0200.
  - Three dma_ack pulses appear only on req_dma_ack[2].
  - After dma_end_flag: one RELEASE cycle with ctl_rqst=0, then IDLE.
- Contention: req_rqst=4'b1011 held, each grant ended by dma_end_flag.
  - Grant order is 0,1,3,0, with a 2-cycle gap after each end flag.
- Abort: grant dev1 and issue one dma_ack, then drop req_rqst[1].
  - Next cycle: ctl_rqst=0, grant=0, state IDLE, no end flag forwarded.
  - A pending dev2 is granted on the following cycle.
- Stray strobes: dma_ack=1 and dma_end_flag=1 while IDLE -> req_dma_ack=0, req_dma_end_flag=0, state unchanged.
- Reset mid-BUSY: assert reset while dev3 is granted.
  - Immediately: grant=0, ctl_rqst=0.
  - After release with all requests held: dev0 is granted first.
- DMA_ARB_PRIO0_EN defined: pointer at 0, req_rqst=4'b0011 held across two transfers -> dev0 wins both times. With the macro undefined, the order is 1 then 0.
